// File: rtl/mac_step6.sv
// Writeback/accumulate stage of the FP MAC: packs step5 results into IEEE-754 single,
// holds the running accumulator and hands out the final sum after ACC_LEN terms.
//
// state | meaning
// IDLE  | no accumulation in progress, acc and term_cnt are zero
// ACCUM | terms being accepted, term_cnt < ACC_LEN
// HOLD  | final sum presented on res_data, waiting for res_ready
module mac_step6 #(
    parameter int unsigned ACC_LEN = 16
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_s,
    input  logic [7:0]  out_ex,
    input  logic [23:0] out_sg,
    output logic [31:0] acc,
    output logic [7:0]  term_cnt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        ovf_flag,
    output logic        uf_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LEN8 = 8'(ACC_LEN);

    state_t      state_q;
    logic [31:0] acc_q;
    logic [7:0]  cnt_q;
    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic        ovf_q;
    logic        uf_q;

    logic [31:0] pack_d;
    logic        ovf_d;
    logic        uf_d;
    logic [7:0]  cnt_d;

    // Priority: zero significand, then infinity, then denormal flush, then normal.
    always_comb begin
        pack_d = {out_s, 31'b0};
        ovf_d  = 1'b0;
        uf_d   = 1'b0;
        if (!out_sg[23]) begin
            pack_d = {out_s, 31'b0};
        end else if (out_ex == 8'hFF) begin
            pack_d = {out_s, 8'hFF, 23'b0};
            ovf_d  = 1'b1;
        end else if (out_ex == 8'h00) begin
            pack_d = {out_s, 31'b0};
            uf_d   = 1'b1;
        end else begin
            pack_d = {out_s, out_ex, out_sg[22:0]};
        end
    end

    assign cnt_d = cnt_q + 8'd1;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            ovf_q       <= 1'b0;
            uf_q        <= 1'b0;
        end else if (clr) begin
            // res_data deliberately survives an abort
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            uf_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc_q <= pack_d;
                        cnt_q <= cnt_d;
                        if (ovf_d) ovf_q <= 1'b1;
                        if (uf_d)  uf_q  <= 1'b1;
                        if (cnt_d == LEN8) begin
                            state_q     <= HOLD;
                            res_data_q  <= pack_d;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        res_valid_q <= 1'b0;
                        ovf_q       <= 1'b0;
                        uf_q        <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign acc       = acc_q;
    assign term_cnt  = cnt_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign ovf_flag  = ovf_q;
    assign uf_flag   = uf_q;

endmodule

// File: tb/tb_mac_step6.sv
// Bench for mac_step6: directed scenarios on ACC_LEN=4 and ACC_LEN=1 instances,
// plus a randomized run against a behavioural accumulation model.
module tb_mac_step6;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESETn, clr, in_valid, out_s, res_ready;
    logic [7:0]  out_ex;
    logic [23:0] out_sg;

    logic        rdy4, rv4, ovf4, uf4;
    logic [31:0] acc4, rd4;
    logic [7:0]  cnt4;
    logic        rdy1, rv1, ovf1, uf1;
    logic [31:0] acc1, rd1;
    logic [7:0]  cnt1;

    mac_step6 #(.ACC_LEN(4)) u4 (
        .CLK(CLK), .RESETn(RESETn), .clr(clr), .in_valid(in_valid), .in_ready(rdy4),
        .out_s(out_s), .out_ex(out_ex), .out_sg(out_sg), .acc(acc4), .term_cnt(cnt4),
        .res_valid(rv4), .res_ready(res_ready), .res_data(rd4), .ovf_flag(ovf4), .uf_flag(uf4)
    );

    mac_step6 #(.ACC_LEN(1)) u1 (
        .CLK(CLK), .RESETn(RESETn), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .out_s(out_s), .out_ex(out_ex), .out_sg(out_sg), .acc(acc1), .term_cnt(cnt1),
        .res_valid(rv1), .res_ready(res_ready), .res_data(rd1), .ovf_flag(ovf1), .uf_flag(uf1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the ACC_LEN=4 instance: a list of accepted terms.
    logic [31:0] m_terms[$];
    bit          m_hold, m_rv, m_ovf, m_uf;
    logic [31:0] m_rd;

    function automatic logic [31:0] ref_pack(bit s, int unsigned ex, int unsigned sg);
        int unsigned sbit;
        sbit = s ? 32'h8000_0000 : 32'h0;
        if (sg < 32'h80_0000) return sbit;
        if (ex == 255)        return sbit + 32'h7F80_0000;
        if (ex == 0)          return sbit;
        return sbit + ex * 32'h80_0000 + (sg - 32'h80_0000);
    endfunction

    task automatic model_edge();
        if (!RESETn) begin
            m_terms.delete(); m_hold = 0; m_rv = 0; m_ovf = 0; m_uf = 0; m_rd = '0;
        end else if (clr) begin
            m_terms.delete(); m_hold = 0; m_rv = 0; m_ovf = 0; m_uf = 0;
        end else if (m_hold) begin
            if (res_ready) begin
                m_terms.delete(); m_hold = 0; m_rv = 0; m_ovf = 0; m_uf = 0;
            end
        end else if (in_valid) begin
            m_terms.push_back(ref_pack(out_s, out_ex, out_sg));
            if (out_sg >= 24'h80_0000 && out_ex == 8'hFF) m_ovf = 1;
            if (out_sg >= 24'h80_0000 && out_ex == 8'h00) m_uf = 1;
            if (m_terms.size() == 4) begin
                m_hold = 1; m_rv = 1; m_rd = m_terms[3];
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(bit v, bit s, logic [7:0] ex, logic [23:0] sg);
        in_valid = v; out_s = s; out_ex = ex; out_sg = sg;
    endtask

    task automatic test_reset();
        RESETn = 0; clr = 0; res_ready = 0; drive(0, 0, 8'd0, 24'd0);
        step(); step();
        RESETn = 1;
        n_checks++;
        if ({acc4, cnt4, rv4, rd4, ovf4, uf4, rdy4} !== {32'h0, 8'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: acc=%h cnt=%0d rv=%b rd=%h ovf=%b uf=%b rdy=%b, want zeros with rdy=1",
                     acc4, cnt4, rv4, rd4, ovf4, uf4, rdy4);
        end
    endtask

    task automatic test_single();
        drive(1, 0, 8'd127, 24'h80_0000);
        step();
        drive(0, 0, 8'd0, 24'd0);
        n_checks++;
        if (acc4 !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_acc: got %h want 3f800000", acc4); end
        n_checks++;
        if (cnt4 !== 8'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", cnt4); end
        n_checks++;
        if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %b want 1", rdy4); end
    endtask

    task automatic test_hold();
        drive(1, 0, 8'd130, 24'hA0_0000); step();
        drive(1, 1, 8'd100, 24'hFF_FFFF); step();
        drive(1, 1, 8'd128, 24'hC0_0000); step();
        n_checks++;
        if ({rv4, rd4, rdy4, cnt4} !== {1'b1, 32'hC040_0000, 1'b0, 8'd4}) begin
            n_fail++;
            $display("FAIL hold_entry: rv=%b rd=%h rdy=%b cnt=%0d, want rv=1 rd=c0400000 rdy=0 cnt=4",
                     rv4, rd4, rdy4, cnt4);
        end
        drive(1, 0, 8'd1, 24'h80_0001);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({rv4, rd4, acc4, cnt4} !== {1'b1, 32'hC040_0000, 32'hC040_0000, 8'd4}) begin
                n_fail++;
                $display("FAIL hold_stall[%0d]: rv=%b rd=%h acc=%h cnt=%0d", i, rv4, rd4, acc4, cnt4);
            end
        end
        drive(0, 0, 8'd0, 24'd0);
        res_ready = 1; step(); res_ready = 0;
        n_checks++;
        if ({rv4, acc4, cnt4, rdy4} !== {1'b0, 32'h0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_release: rv=%b acc=%h cnt=%0d rdy=%b, want 0/0/0/1", rv4, acc4, cnt4, rdy4);
        end
    endtask

    task automatic test_special();
        drive(1, 1, 8'h85, 24'h00_0000); step();
        n_checks++;
        if (acc4 !== 32'h8000_0000) begin n_fail++; $display("FAIL sp_negzero: got %h want 80000000", acc4); end
        drive(1, 0, 8'hFF, 24'h80_0001); step();
        n_checks++;
        if ({acc4, ovf4, uf4} !== {32'h7F80_0000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL sp_inf: acc=%h ovf=%b uf=%b want 7f800000/1/0", acc4, ovf4, uf4);
        end
        drive(1, 0, 8'h00, 24'h80_0000); step();
        n_checks++;
        if ({acc4, ovf4, uf4} !== {32'h0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL sp_denorm: acc=%h ovf=%b uf=%b want 0/1/1", acc4, ovf4, uf4);
        end
        drive(1, 0, 8'd127, 24'h80_0000); step();
        drive(0, 0, 8'd0, 24'd0); step();
        n_checks++;
        if ({rv4, ovf4, uf4} !== 3'b111) begin
            n_fail++; $display("FAIL sp_flags_hold: rv=%b ovf=%b uf=%b want 1/1/1", rv4, ovf4, uf4);
        end
        res_ready = 1; step(); res_ready = 0;
        n_checks++;
        if ({ovf4, uf4} !== 2'b00) begin
            n_fail++; $display("FAIL sp_flags_clear: ovf=%b uf=%b want 0/0", ovf4, uf4);
        end
    endtask

    task automatic test_clr();
        drive(1, 0, 8'd140, 24'h90_0000); step();
        drive(1, 0, 8'hFF, 24'h80_0000); step();
        n_checks++;
        if (cnt4 !== 8'd2) begin n_fail++; $display("FAIL clr_pre: cnt got %0d want 2", cnt4); end
        drive(1, 0, 8'd120, 24'h88_0000); clr = 1; step(); clr = 0;
        drive(0, 0, 8'd0, 24'd0);
        n_checks++;
        if ({acc4, cnt4, rdy4, rv4, ovf4} !== {32'h0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL clr_accum: acc=%h cnt=%0d rdy=%b rv=%b ovf=%b", acc4, cnt4, rdy4, rv4, ovf4);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'(126 + i), 24'hB0_0000 + 24'(i)); step();
        end
        drive(0, 0, 8'd0, 24'd0);
        n_checks++;
        if ({rv4, rd4} !== {1'b1, ref_pack(1, 129, 32'hB0_0003)}) begin
            n_fail++; $display("FAIL clr_fill: rv=%b rd=%h want 1/%h", rv4, rd4, ref_pack(1, 129, 32'hB0_0003));
        end
        clr = 1; drive(1, 0, 8'd127, 24'h80_0000); step(); clr = 0;
        drive(0, 0, 8'd0, 24'd0);
        n_checks++;
        if ({rv4, rd4, rdy4, cnt4, acc4} !== {1'b0, ref_pack(1, 129, 32'hB0_0003), 1'b1, 8'd0, 32'h0}) begin
            n_fail++; $display("FAIL clr_hold: rv=%b rd=%h rdy=%b cnt=%0d acc=%h", rv4, rd4, rdy4, cnt4, acc4);
        end
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'hFF, 24'h80_0000); step();
        end
        drive(0, 0, 8'd0, 24'd0);
        RESETn = 0; res_ready = 0;
        #2;
        n_checks++;
        if ({rv4, cnt4, ovf4} !== {1'b1, 8'd4, 1'b1}) begin
            n_fail++; $display("FAIL rst_sync: rv=%b cnt=%0d ovf=%b changed before edge", rv4, cnt4, ovf4);
        end
        step(); RESETn = 1;
        n_checks++;
        if ({acc4, cnt4, rv4, rd4, ovf4, uf4} !== {32'h0, 8'd0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rst_hold: acc=%h cnt=%0d rv=%b rd=%h ovf=%b uf=%b want zeros",
                               acc4, cnt4, rv4, rd4, ovf4, uf4);
        end
    endtask

    task automatic test_len1();
        drive(1, 0, 8'd131, 24'hC8_0000); step();
        drive(0, 0, 8'd0, 24'd0);
        n_checks++;
        if ({rv1, cnt1, rdy1, rd1, acc1} !== {1'b1, 8'd1, 1'b0, ref_pack(0, 131, 32'hC8_0000), ref_pack(0, 131, 32'hC8_0000)}) begin
            n_fail++; $display("FAIL len1_hold: rv=%b cnt=%0d rdy=%b rd=%h acc=%h", rv1, cnt1, rdy1, rd1, acc1);
        end
        res_ready = 1; step(); res_ready = 0;
        n_checks++;
        if ({rv1, cnt1, rdy1} !== {1'b0, 8'd0, 1'b1}) begin
            n_fail++; $display("FAIL len1_release: rv=%b cnt=%0d rdy=%b", rv1, cnt1, rdy1);
        end
    endtask

    task automatic test_random();
        logic [31:0] e_acc;
        RESETn = 0; clr = 0; res_ready = 0; drive(0, 0, 8'd0, 24'd0); step(); RESETn = 1;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_s     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       out_ex = 8'h00;
                1:       out_ex = 8'hFF;
                default: out_ex = 8'($urandom_range(0, 255));
            endcase
            out_sg    = ($urandom_range(0, 9) == 0) ? 24'($urandom_range(0, 32'h7F_FFFF))
                                                   : 24'($urandom_range(32'h80_0000, 32'hFF_FFFF));
            res_ready = ($urandom_range(0, 9) < 3);
            clr       = ($urandom_range(0, 49) == 0);
            RESETn    = ($urandom_range(0, 99) != 0);
            step();
            e_acc = (m_terms.size() == 0) ? 32'h0 : m_terms[m_terms.size() - 1];
            n_checks++;
            if ({acc4, cnt4, rv4, rd4, ovf4, uf4, rdy4} !==
                {e_acc, 8'(m_terms.size()), m_rv, m_rd, m_ovf, m_uf, !m_hold}) begin
                n_fail++;
                $display("FAIL rand[%0d]: acc=%h cnt=%0d rv=%b rd=%h ovf=%b uf=%b rdy=%b want %h %0d %b %h %b %b %b",
                         c, acc4, cnt4, rv4, rd4, ovf4, uf4, rdy4,
                         e_acc, m_terms.size(), m_rv, m_rd, m_ovf, m_uf, !m_hold);
            end
        end
        RESETn = 1; clr = 0; res_ready = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_special();
        test_clr();
        test_reset_hold();
        test_len1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_step6.md
Name: mac_step6

Overview:
- Writeback/accumulate stage directly downstream of the normalize-and-round stage (step5) of the floating-point MAC pipeline.
- Packs step5's {sign, exponent, 24-bit significand with explicit hidden bit} into an IEEE-754 single word.
- Holds that word as the running accumulator fed back to the front of the MAC.
- Counts accumulated terms and hands the final sum out over a valid/ready handshake.

Parameters:
ACC_LEN, 16, number of terms per accumulation; legal range 1..255

Ports:
CLK  input  1  clock; all state changes on rising edge
RESETn  input  1  synchronous active-low reset, sampled on rising edge of CLK
clr  input  1  synchronous abort: discard the current accumulation and return to IDLE
in_valid  input  1  step5 result valid this cycle
in_ready  output  1  stage can accept a step5 result
out_s  input  1  result sign from step5
out_ex  input  8  biased exponent from step5
out_sg  input  24  significand from step5; bit 23 is the hidden bit
acc  output  32  current packed accumulator, fed back to step1
term_cnt  output  8  terms accepted in the current accumulation
res_valid  output  1  final accumulation result available
res_ready  input  1  consumer accepts the result
res_data  output  32  final packed result
ovf_flag  output  1  sticky: a term saturated to infinity
uf_flag  output  1  sticky: a term was flushed to zero

Behaviour:
- Reset (RESETn low at a rising edge) overrides everything, in any state including HOLD. Outputs after reset: acc=0, term_cnt=0, res_valid=0, res_data=0, ovf_flag=0, uf_flag=0, state=IDLE.
- Accept condition: a term is accepted when in_valid && in_ready at a rising edge.
- in_ready is 1 in IDLE and ACCUM and 0 in HOLD.
- A term presented while in_ready=0 is not consumed; upstream holds it stable.
- Pack function, combinational on the inputs, evaluated in priority order:
  1. out_sg[23]==0 → {out_s, 31'b0} (signed zero).
  2. out_ex==8'hFF → {out_s, 8'hFF, 23'b0} (infinity); set ovf_flag.
  3. out_ex==8'h00 → {out_s, 31'b0} (denormals unsupported); set uf_flag.
  4. Otherwise → {out_s, out_ex, out_sg[22:0]}.
- Latency: acc shows the packed value of an accepted term on the cycle after acceptance.
- term_cnt increments by 1 per accepted term, in the same cycle acc updates.
- FSM:
  - IDLE: acc=0, term_cnt=0. An accepted term → ACCUM, with acc=pack and term_cnt=1. If ACC_LEN==1 → HOLD instead.
  - ACCUM: each accepted term sets acc=pack and term_cnt+1. When the accepted term makes term_cnt==ACC_LEN → HOLD. On that same edge res_data<=pack and res_valid<=1.
  - HOLD: res_valid=1; res_data and acc are held stable. When res_ready=1 at an edge → IDLE, with res_valid=0, acc=0, term_cnt=0, ovf_flag=0, uf_flag=0. While res_ready=0, stay in HOLD indefinitely.
- clr: highest priority after reset, in any state. On the next edge: state=IDLE, acc=0, term_cnt=0, res_valid=0, ovf_flag=0, uf_flag=0. res_data keeps its last value. in_valid in the same cycle is not consumed, even though in_ready=1.
- Sticky flags are set on the edge that accepts the offending term and stay set through HOLD. They clear only on reset, clr, or the HOLD handshake.
- res_data changes only on entry to HOLD.
- term_cnt never exceeds ACC_LEN and never wraps.

Test Plan:
1. Reset, then with ACC_LEN=4 accept {0, 8'd127, 24'h800000} → acc=32'h3F800000 and term_cnt=1 the next cycle; in_ready stays 1.
2. Accept four terms, the last being {1, 8'd128, 24'hC00000} → on the 4th edge res_valid=1 and res_data=32'hC0400000. in_ready=0; in_valid held high is not consumed for 5 cycles with res_ready=0. Raising res_ready → next cycle res_valid=0, acc=0, term_cnt=0.
3. Special packs:
   - out_sg=0 with sign 1 → acc=32'h80000000.
   - out_ex=8'hFF, out_sg=24'h800001 → acc=32'h7F800000 and ovf_flag=1.
   - out_ex=0, out_sg=24'h800000 → acc=0 and uf_flag=1.
   - Both flags persist until the HOLD handshake.
4. Assert clr together with in_valid mid-ACCUM (term_cnt=2) → next cycle IDLE, acc=0, term_cnt=0, and the term is not counted. Repeat in HOLD → res_valid drops while res_data is unchanged.
5. Drive RESETn=0 for one cycle in HOLD with res_ready=0 → all outputs zero on the following cycle, with no reset effect before the clock edge (synchronous). With ACC_LEN=1, a single accepted term → HOLD immediately with term_cnt=1.
